// File: rtl/cook_timer_ctrl_pkg.sv
// cook_timer_ctrl_pkg: state encoding, time constants and saturating +30 s helper
package cook_timer_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSED = 2'd2, ST_FINISHED = 2'd3} state_t;
  typedef struct packed {
    logic [6:0] m;
    logic [6:0] s;
  } mmss_t;
  localparam logic [6:0] SEC_MAX = 7'd59;
  localparam logic [6:0] ADD_SECS = 7'd30;
  localparam logic [6:0] QUICK_START_SECS = 7'd30;
  function automatic mmss_t add_secs(input mmss_t t, input logic [6:0] max_min);
    logic [7:0] s;
    logic [7:0] m;
    s = {1'b0, t.s} + {1'b0, ADD_SECS};
    m = {1'b0, t.m};
    if (s > {1'b0, SEC_MAX}) begin
      s = s - 8'd60;
      m = m + 8'd1;
    end
    add_secs = (m > {1'b0, max_min}) ? {max_min, SEC_MAX} : {m[6:0], s[6:0]};
  endfunction
endpackage

// File: rtl/cook_timer_ctrl_tick_gen.sv
// tick_gen: prescaler pulsing tick for one cycle every TICK_COUNT enabled cycles
module tick_gen #(
  parameter int TICK_COUNT = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_COUNT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = en && (cnt_q == W'(TICK_COUNT - 1));
    cnt_d = (clr || tick) ? '0 : en ? cnt_q + W'(1) : cnt_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: microwave countdown with door interlock, +30 s, heater duty cycling and end beep
module cook_timer_ctrl
  import cook_timer_ctrl_pkg::*;
#(
  parameter int TICK_COUNT = 100_000_000,
  parameter int MAX_MIN = 99,
  parameter int POWER_LEVELS = 10,
  parameter int BEEP_TICKS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       add30,
  input  logic       door_open,
  input  logic [3:0] power,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  output logic [6:0] min_left,
  output logic [6:0] sec_left,
  output logic [1:0] state,
  output logic       busy,
  output logic       done,
  output logic       heater,
  output logic       beep
);
  localparam int BW = $clog2(BEEP_TICKS + 1);
  state_t state_q, state_d;
  mmss_t time_q, time_d, preset, stepped;
  logic [3:0] btn_q, btn_d, power_q, power_d, slot_q, slot_d;
  logic [BW-1:0] beep_q, beep_d;
  logic done_q, done_d, start_e, stop_e, pause_e, add30_e, tick, tick_en, tick_clr;
  tick_gen #(.TICK_COUNT(TICK_COUNT)) u_tick (
    .clock(clock),
    .reset(reset),
    .en(tick_en),
    .clr(tick_clr),
    .tick(tick)
  );
  always_comb begin
    btn_d = {start, stop, pause, add30};
    {start_e, stop_e, pause_e, add30_e} = btn_d & ~btn_q;
    preset = {min > 7'(MAX_MIN) ? 7'(MAX_MIN) : min, sec > SEC_MAX ? SEC_MAX : sec};
    power_d = power > 4'(POWER_LEVELS) ? 4'(POWER_LEVELS) : power;
    stepped = !tick ? time_q : (time_q.s != '0) ? {time_q.m, time_q.s - 7'd1} : {time_q.m - 7'd1, SEC_MAX};
    state_d = state_q;
    time_d = time_q;
    beep_d = beep_q;
    case (state_q)
      ST_IDLE:
        if (start_e && !door_open) begin
          state_d = ST_RUN;
          time_d = (preset == '0) ? mmss_t'({7'd0, QUICK_START_SECS}) : preset;
        end
      ST_RUN:
        if (stop_e) state_d = ST_IDLE;
        else if (door_open || pause_e) state_d = ST_PAUSED;
        else begin
          time_d = add30_e ? add_secs(stepped, 7'(MAX_MIN)) : stepped;
          if (time_d == '0) state_d = ST_FINISHED;
        end
      ST_PAUSED:
        if (stop_e) state_d = ST_IDLE;
        else begin
          if (add30_e) time_d = add_secs(time_q, 7'(MAX_MIN));
          if ((start_e || pause_e) && !door_open) state_d = ST_RUN;
        end
      ST_FINISHED:
        if (stop_e) state_d = ST_IDLE;
        else if (tick) begin
          beep_d = beep_q + BW'(1);
          if (beep_q == BW'(BEEP_TICKS - 1)) state_d = ST_IDLE;
        end
    endcase
    // idle always mirrors the clamped preset, including the first cycle after stop/beep
    if (state_d == ST_IDLE) time_d = preset;
    done_d = (state_q == ST_RUN) && (state_d == ST_FINISHED);
    if (done_d) beep_d = '0;
    tick_en = (state_q == ST_RUN) || (state_q == ST_FINISHED);
    tick_clr = (state_q == ST_IDLE) || done_d;
    slot_d = (state_q == ST_IDLE) ? '0 : (state_q == ST_RUN && tick) ? ((slot_q == 4'(POWER_LEVELS - 1)) ? '0 : slot_q + 4'd1) : slot_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      time_q <= '0;
      btn_q <= '0;
      power_q <= '0;
      slot_q <= '0;
      beep_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q <= time_d;
      btn_q <= btn_d;
      power_q <= power_d;
      slot_q <= slot_d;
      beep_q <= beep_d;
      done_q <= done_d;
    end
  assign state = state_q;
  assign min_left = time_q.m;
  assign sec_left = time_q.s;
  assign busy = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign done = done_q;
  assign heater = (state_q == ST_RUN) && !door_open && (slot_q < power_q);
  assign beep = state_q == ST_FINISHED;
endmodule

// File: tb/tb_cook_timer_ctrl.sv
// tb_cook_timer_ctrl: directed + randomized stimulus scored against a total-seconds reference model
module tb_cook_timer_ctrl;
  localparam int TC = 4, MAXM = 99, PL = 10, BT = 3, MAXT = MAXM * 60 + 59;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_FIN = 3;
  logic clock = 0, reset = 1, start = 0, stop = 0, pause = 0, add30 = 0, door_open = 0;
  logic [3:0] power = 0;
  logic [6:0] min = 0, sec = 0, min_left, sec_left;
  logic [1:0] state;
  logic busy, done, heater, beep;
  typedef struct packed {
    logic [6:0] m;
    logic [6:0] s;
    logic [1:0] st;
    logic busy, done, heater, beep;
  } obs_t;
  obs_t exp_q[$];
  int checks = 0, passed = 0;
  int m_st, m_tot, m_phase, m_slot, m_beeps, m_pwr, m_done;
  logic [3:0] m_prev;

  cook_timer_ctrl #(.TICK_COUNT(TC), .MAX_MIN(MAXM), .POWER_LEVELS(PL), .BEEP_TICKS(BT)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause), .add30(add30),
    .door_open(door_open), .power(power), .min(min), .sec(sec), .min_left(min_left),
    .sec_left(sec_left), .state(state), .busy(busy), .done(done), .heater(heater), .beep(beep)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_st = S_IDLE; m_tot = 0; m_phase = 0; m_slot = 0; m_beeps = 0; m_pwr = 0; m_done = 0; m_prev = '0;
  endtask

  function automatic int sat(input int t);
    return t > MAXT ? MAXT : t;
  endfunction

  // one clock edge of the reference: time kept as total seconds, phase as cycles into the second
  task automatic model_edge();
    int nst, ntot, nph, nsl, preset, pm, ps;
    bit en, tk, se, so, pe, ae;
    pm = int'(min); ps = int'(sec);
    preset = (pm > MAXM ? MAXM : pm) * 60 + (ps > 59 ? 59 : ps);
    {se, so, pe, ae} = {start, stop, pause, add30} & ~m_prev;
    en = m_st == S_RUN || m_st == S_FIN;
    tk = en && m_phase == TC - 1;
    nst = m_st; ntot = m_tot; nsl = m_slot;
    nph = en ? (m_phase + 1) % TC : m_phase;
    if (m_st == S_RUN && tk) nsl = (m_slot + 1) % PL;
    m_done = 0;
    case (m_st)
      S_IDLE: if (se && !door_open) begin
        nst = S_RUN; ntot = preset == 0 ? 30 : preset; nph = 0; nsl = 0;
      end
      S_RUN: if (so) nst = S_IDLE;
        else if (door_open || pe) nst = S_PAUSED;
        else begin
          ntot = m_tot - (tk ? 1 : 0);
          if (ae) ntot = sat(ntot + 30);
          if (ntot == 0) begin nst = S_FIN; m_done = 1; nph = 0; m_beeps = 0; end
        end
      S_PAUSED: if (so) nst = S_IDLE;
        else begin
          if (ae) ntot = sat(m_tot + 30);
          if ((se || pe) && !door_open) nst = S_RUN;
        end
      default: if (so) nst = S_IDLE;
        else if (tk) begin
          m_beeps++;
          if (m_beeps == BT) nst = S_IDLE;
        end
    endcase
    if (nst == S_IDLE) ntot = preset;
    m_st = nst; m_tot = ntot; m_phase = nph; m_slot = nsl;
    m_pwr = power > PL ? PL : int'(power);
    m_prev = {start, stop, pause, add30};
  endtask

  function automatic obs_t expected();
    obs_t e;
    e.m = 7'(m_tot / 60);
    e.s = 7'(m_tot % 60);
    e.st = 2'(m_st);
    e.busy = m_st == S_RUN || m_st == S_PAUSED;
    e.done = m_done != 0;
    e.heater = m_st == S_RUN && !door_open && m_slot < m_pwr;
    e.beep = m_st == S_FIN;
    return e;
  endfunction

  // called at posedge+1 after inputs are set; expectation is checked at the following negedge
  task automatic cyc(input int n = 1);
    repeat (n) begin
      if (reset) model_reset();
      exp_q.push_back(expected());
      @(posedge clock);
      if (reset) model_reset(); else model_edge();
      #1;
    end
  endtask

  task automatic press(input int b);
    case (b)
      0: start = 1;
      1: stop = 1;
      2: pause = 1;
      default: add30 = 1;
    endcase
    cyc(1);
    {start, stop, pause, add30} = '0;
  endtask

  task automatic preset_to(input int m, input int s);
    min = 7'(m); sec = 7'(s);
  endtask

  always @(negedge clock) if (exp_q.size() != 0) begin
    obs_t e, a;
    e = exp_q.pop_front();
    a = {min_left, sec_left, state, busy, done, heater, beep};
    checks++;
    if (a === e) passed++;
    else $display("FAIL outputs @%0t got %0d:%0d st=%0d busy=%0d done=%0d heater=%0d beep=%0d want %0d:%0d st=%0d busy=%0d done=%0d heater=%0d beep=%0d",
                  $time, a.m, a.s, a.st, a.busy, a.done, a.heater, a.beep, e.m, e.s, e.st, e.busy, e.done, e.heater, e.beep);
  end

  initial begin
    model_reset();
    @(posedge clock); #1;
    power = 10; preset_to(1, 5);
    cyc(3);
    reset = 0;
    cyc(3);
    press(0); cyc(290);
    preset_to(0, 0); cyc(2);
    press(0); cyc(9); press(3); cyc(30); press(1); cyc(2);
    preset_to(99, 51); cyc(2);
    press(0); cyc(5); press(3); cyc(6); press(3); cyc(5); press(1); cyc(2);
    preset_to(0, 10); cyc(2);
    press(0); cyc(5); press(2); cyc(8); press(2); cyc(12); press(1); cyc(2);
    press(0); cyc(6); door_open = 1; cyc(3); press(0); cyc(3); door_open = 0; cyc(2);
    press(0); cyc(8); press(1); cyc(2);
    power = 3; preset_to(2, 0); cyc(2);
    press(0); cyc(90); power = 12; cyc(50); power = 0; cyc(50); press(1); cyc(2);
    power = 10; preset_to(120, 75); cyc(3);
    press(0); cyc(10); press(1); cyc(3);
    preset_to(0, 1); cyc(2); press(0); cyc(6); press(1); cyc(3);
    preset_to(0, 2); cyc(2); press(0); cyc(10);
    reset = 1; cyc(2); reset = 0; cyc(3);
    for (int i = 0; i < 1500; i++) begin
      start = $urandom_range(0, 11) == 0;
      stop = $urandom_range(0, 59) == 0;
      pause = $urandom_range(0, 15) == 0;
      add30 = $urandom_range(0, 11) == 0;
      if ($urandom_range(0, 29) == 0) door_open = ~door_open;
      if ($urandom_range(0, 49) == 0) power = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0)
        preset_to($urandom_range(0, 19) == 0 ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 2)), int'($urandom_range(0, 70)));
      cyc(1);
    end
    {start, stop, pause, add30, door_open} = '0;
    cyc(2);
    @(negedge clock); #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
